// File: rtl/ebpc_pkg.sv
// Shared EBPC parameters and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ebpc_pkg;

   localparam int DATA_W     = 8;
   localparam int BLOCK_SIZE = 8;

   // Merge stage: RUN pairs flags with BPC words, DRAIN swallows block padding.
   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } dec_merge_state_t;

endpackage

// File: rtl/ebpc_decoder_merge.sv
// Re-inserts zero words into the BPC nonzero stream, drops final-block padding, checks BPC last.
// Latency: 1 cycle from flag handshake to vld_o; 1 word/cycle sustained.
// Backpressure: single output register; both inputs stall while it is full and rdy_i is low.
module ebpc_decoder_merge #(
   parameter int DATA_W     = ebpc_pkg::DATA_W,
   parameter int BLOCK_SIZE = ebpc_pkg::BLOCK_SIZE
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flag_i,
   input  logic              flag_last_i,
   input  logic              flag_vld_i,
   output logic              flag_rdy_o,
   input  logic [DATA_W-1:0] bpc_data_i,
   input  logic              bpc_last_i,
   input  logic              bpc_vld_i,
   output logic              bpc_rdy_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic              vld_o,
   input  logic              rdy_i,
   output logic              idle_o,
   output logic              err_o
);
   import ebpc_pkg::*;

   localparam int CNT_W = $clog2(BLOCK_SIZE);

   dec_merge_state_t  r_state;
   dec_merge_state_t  w_state_nxt;
   logic [CNT_W-1:0]  r_block_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [CNT_W-1:0]  w_cnt_post;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic              r_vld;
   logic              r_err;
   logic              w_out_free;
   logic              w_flag_rdy;
   logic              w_bpc_rdy;
   logic              w_flag_hs;
   logic              w_bpc_hs;
   logic              w_bpc_final;
   logic              w_err;

   assign w_out_free = !r_vld || rdy_i;

   // A nonzero flag can only be taken together with its BPC word, so both sides
   // share the same output-free condition and transfer in the same cycle.
   assign w_flag_rdy = (r_state == RUN) && w_out_free && (!flag_i || bpc_vld_i);
   assign w_bpc_rdy  = (r_state == DRAIN) || (w_out_free && flag_vld_i && flag_i);

   assign w_flag_hs  = flag_vld_i && w_flag_rdy;
   assign w_bpc_hs   = bpc_vld_i && w_bpc_rdy;

   assign w_cnt_inc  = r_block_cnt + CNT_W'(1);
   assign w_cnt_post = w_bpc_hs ? w_cnt_inc : r_block_cnt;

   // Next state, and whether the BPC word consumed this cycle closes the stream.
   always_comb begin
      w_state_nxt = r_state;
      w_bpc_final = 1'b0;
      if (r_state == RUN) begin
         if (w_flag_hs && flag_last_i) begin
            if (w_cnt_post != '0) begin
               w_state_nxt = DRAIN;
            end else begin
               // Stream ended exactly on a block boundary (or had no BPC words).
               w_bpc_final = w_bpc_hs;
            end
         end
      end else begin
         if (w_bpc_hs && (w_cnt_inc == '0)) begin
            w_state_nxt = RUN;
            w_bpc_final = 1'b1;
         end
      end
   end

   // bpc_last_i must be set on exactly the final word of each stream.
   assign w_err = w_bpc_hs && (bpc_last_i != w_bpc_final);

   // State and block position; a mid-stream reset abandons any partial block.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= RUN;
         r_block_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_block_cnt <= w_cnt_post;
      end
   end

   // Output register: load on flag handshake, otherwise empty when popped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld  <= 1'b0;
         r_data <= '0;
         r_last <= 1'b0;
      end else if (w_flag_hs) begin
         r_vld  <= 1'b1;
         r_data <= flag_i ? bpc_data_i : '0;
         r_last <= flag_last_i;
      end else if (rdy_i) begin
         r_vld  <= 1'b0;
      end
   end

   // One-cycle error pulse following a misaligned BPC last.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_err;
      end
   end

   assign flag_rdy_o = w_flag_rdy;
   assign bpc_rdy_o  = w_bpc_rdy;
   assign data_o     = r_data;
   assign last_o     = r_last;
   assign vld_o      = r_vld;
   assign err_o      = r_err;
   assign idle_o     = (r_state == RUN) && (r_block_cnt == '0) && !r_vld;

endmodule

// File: tb/tb_ebpc_decoder_merge.sv
// Scoreboard bench for ebpc_decoder_merge: directed streams, expected words queued at issue.
// Latency: n/a.
// Backpressure: random rdy_i and BPC gaps in one scenario.
module tb_ebpc_decoder_merge;
   import ebpc_pkg::*;

   typedef struct packed { logic f; logic l; } flag_item_t;
   typedef struct packed { logic [7:0] d; logic l; } word_item_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       flag_i = 1'b0, flag_last_i = 1'b0, flag_vld_i = 1'b0;
   logic       flag_rdy_o;
   logic [7:0] bpc_data_i = '0;
   logic       bpc_last_i = 1'b0, bpc_vld_i = 1'b0;
   logic       bpc_rdy_o;
   logic [7:0] data_o;
   logic       last_o, vld_o, idle_o, err_o;
   logic       rdy_i = 1'b1;

   ebpc_decoder_merge dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .flag_i(flag_i), .flag_last_i(flag_last_i), .flag_vld_i(flag_vld_i), .flag_rdy_o(flag_rdy_o),
      .bpc_data_i(bpc_data_i), .bpc_last_i(bpc_last_i), .bpc_vld_i(bpc_vld_i), .bpc_rdy_o(bpc_rdy_o),
      .data_o(data_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i),
      .idle_o(idle_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   flag_item_t flag_q[$];
   word_item_t bpc_q[$];
   word_item_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   int bpc_acc = 0;
   int bpc_rdy_seen = 0;
   int drain_cycles = 0;
   bit rdy_rand = 0;
   bit gap_en = 0;
   bit prev_stall = 0;
   word_item_t prev_out;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Output ready: either always on or a coin toss each cycle.
   always @(posedge clk_i) begin
      #1;
      rdy_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: pops the scoreboard on every output handshake and watches side signals.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (prev_stall && vld_o) begin
            chk("stall_hold", {23'd0, data_o, last_o}, {23'd0, prev_out.d, prev_out.l});
         end
         if (vld_o && rdy_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               word_item_t e;
               e = exp_q.pop_front();
               chk("out_word", {23'd0, data_o, last_o}, {23'd0, e.d, e.l});
            end
         end
         prev_stall = vld_o && !rdy_i;
         prev_out   = '{d: data_o, l: last_o};
         if (err_o) err_cnt++;
         if (bpc_vld_i && bpc_rdy_o) bpc_acc++;
         if (bpc_rdy_o) bpc_rdy_seen++;
         if (dut.r_state == DRAIN) drain_cycles++;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic drive_flags();
      int budget = 0;
      while (flag_q.size() > 0) begin
         flag_vld_i  = 1'b1;
         flag_i      = flag_q[0].f;
         flag_last_i = flag_q[0].l;
         @(negedge clk_i);
         if (flag_rdy_o) void'(flag_q.pop_front());
         @(posedge clk_i); #1;
         budget++;
         if (budget > 500) begin
            chk("flag_timeout", 32'd1, 32'd0);
            flag_q.delete();
         end
      end
      flag_vld_i = 1'b0;
   endtask

   task automatic drive_bpc();
      int budget = 0;
      if (bpc_q.size() > 0) begin
         while (bpc_q.size() > 0) begin
            bpc_vld_i  = !(gap_en && ($urandom_range(0, 2) == 0));
            bpc_data_i = bpc_q[0].d;
            bpc_last_i = bpc_q[0].l;
            @(negedge clk_i);
            if (bpc_vld_i && bpc_rdy_o) void'(bpc_q.pop_front());
            @(posedge clk_i); #1;
            budget++;
            if (budget > 500) begin
               chk("bpc_timeout", 32'd1, 32'd0);
               bpc_q.delete();
            end
         end
         bpc_vld_i  = 1'b0;
         bpc_last_i = 1'b0;
      end
   endtask

   // Scenario 1 stream; mode 1 = stray last on word 2, 2 = missing last on word 8,
   // 3 = only the first four BPC words (stream cut short by reset).
   task automatic load_s1(input int mode);
      flag_q = '{'{f: 0, l: 0}, '{f: 1, l: 0}, '{f: 0, l: 0}, '{f: 1, l: 1}};
      bpc_q  = '{'{d: 8'h11, l: 0}, '{d: 8'h22, l: (mode == 1)}};
      for (int i = 0; i < ((mode == 3) ? 2 : 6); i++) bpc_q.push_back('{d: 8'h00, l: 0});
      if (mode != 3 && mode != 2) bpc_q[7].l = 1'b1;
      exp_q  = '{'{d: 8'h00, l: 0}, '{d: 8'h11, l: 0}, '{d: 8'h00, l: 0}, '{d: 8'h22, l: 1}};
   endtask

   task automatic load_s2();
      flag_q.delete(); bpc_q.delete(); exp_q.delete();
      for (int i = 1; i <= 8; i++) begin
         flag_q.push_back('{f: 1, l: (i == 8)});
         bpc_q.push_back('{d: 8'(i), l: (i == 8)});
         exp_q.push_back('{d: 8'(i), l: (i == 8)});
      end
   endtask

   task automatic run_and_settle(input string nm, input int exp_err, input int exp_bpc);
      err_cnt = 0; bpc_acc = 0; bpc_rdy_seen = 0; drain_cycles = 0;
      fork
         drive_flags();
         drive_bpc();
      join
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (exp_q.size() == 0 && idle_o) break;
      end
      repeat (3) @(negedge clk_i);
      chk({nm, "_outstanding"}, exp_q.size(), 0);
      chk({nm, "_idle"}, {31'd0, idle_o}, 32'd1);
      chk({nm, "_err_pulses"}, err_cnt, exp_err);
      chk({nm, "_bpc_taken"}, bpc_acc, exp_bpc);
      exp_q.delete();
      @(posedge clk_i); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_vld", {31'd0, vld_o}, 32'd0);
      chk("rst_data", {24'd0, data_o}, 32'd0);
      chk("rst_last", {31'd0, last_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_idle", {31'd0, idle_o}, 32'd1);
      @(posedge clk_i); #1;

      load_s1(0);
      run_and_settle("zero_pad", 0, 8);

      load_s2();
      run_and_settle("full_block", 0, 8);
      chk("full_block_no_drain", drain_cycles, 0);

      flag_q.delete(); bpc_q.delete(); exp_q.delete();
      for (int i = 1; i <= 5; i++) begin
         flag_q.push_back('{f: 0, l: (i == 5)});
         exp_q.push_back('{d: 8'h00, l: (i == 5)});
      end
      bpc_vld_i = 1'b1; bpc_data_i = 8'hEE;
      run_and_settle("all_zero", 0, 0);
      chk("all_zero_bpc_rdy", bpc_rdy_seen, 0);
      bpc_vld_i = 1'b0;

      rdy_rand = 1; gap_en = 1;
      load_s1(0);
      run_and_settle("backpressure", 0, 8);
      rdy_rand = 0; gap_en = 0;
      repeat (2) @(posedge clk_i); #1;

      load_s1(1);
      run_and_settle("stray_last", 1, 8);

      load_s1(2);
      run_and_settle("missing_last", 1, 8);

      // Cut the stream two pads into DRAIN, then reset.
      load_s1(3);
      bpc_acc = 0;
      fork
         drive_flags();
         drive_bpc();
      join
      repeat (2) @(negedge clk_i);
      chk("pre_reset_in_drain", {31'd0, idle_o}, 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      exp_q.delete();
      @(negedge clk_i);
      chk("post_reset_vld", {31'd0, vld_o}, 32'd0);
      chk("post_reset_idle", {31'd0, idle_o}, 32'd1);
      @(posedge clk_i); #1;

      load_s2();
      run_and_settle("after_reset", 0, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ebpc_decoder_merge.md
Name: ebpc_decoder_merge

Overview:
Core of the EBPC decoder. It recombines the two decoded sub-streams into the original word stream:
- the per-word nonzero-flag stream from zrle_decoder;
- the nonzero-word stream from bpc_decoder, which arrives in BLOCK_SIZE blocks zero-padded at stream end.

It re-inserts zero words, discards the padding words of the final BPC block, and checks BPC last-alignment. It sits inside ebpc_decoder, between the two sub-decoders and the decoder output port.

Parameters:
DATA_W, ebpc_pkg::DATA_W (8), width of data words
BLOCK_SIZE, ebpc_pkg::BLOCK_SIZE (8), BPC block length in words; power of 2, >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
flag_i  in  1  1 = current word nonzero (take from BPC stream), 0 = zero word
flag_last_i  in  1  flag belongs to last word of stream
flag_vld_i  in  1  flag stream valid
flag_rdy_o  out  1  flag stream ready
bpc_data_i  in  DATA_W  decoded nonzero word or padding word
bpc_last_i  in  1  final BPC word of stream (including padding)
bpc_vld_i  in  1  BPC stream valid
bpc_rdy_o  out  1  BPC stream ready
data_o  out  DATA_W  reconstructed word
last_o  out  1  last word of stream
vld_o  out  1  output valid
rdy_i  in  1  output ready
idle_o  out  1  no stream in flight, output register empty
err_o  out  1  one-cycle pulse on BPC last misalignment

Behaviour:
- Reset (rst_i=1 at clk_i edge):
  - state=RUN, block_cnt=0;
  - vld_o=0, data_o=0, last_o=0, err_o=0.
  - Mid-stream reset discards everything in flight, including a partial block.
- Output register, single stage: out_free = !vld_o || rdy_i.
  - Registered values load on a flag handshake; vld_o then rises next cycle (latency 1).
  - data_o/last_o held stable while vld_o && !rdy_i.
- block_cnt, $clog2(BLOCK_SIZE) bits:
  - counts consumed BPC words modulo BLOCK_SIZE; wraps BLOCK_SIZE-1 -> 0;
  - increments on every bpc_vld_i && bpc_rdy_o.
- State RUN:
  - flag_rdy_o = out_free && (!flag_i || bpc_vld_i).
  - bpc_rdy_o = out_free && flag_vld_i && flag_i.
  - Flag and BPC word transfer in the same cycle; flag_rdy_o may depend on flag_i/bpc_vld_i.
  - On flag handshake: data_o <= flag_i ? bpc_data_i : 0; last_o <= flag_last_i.
  - If flag_last_i is accepted and the post-increment block_cnt != 0, go to DRAIN; otherwise stay in RUN (stream complete).
- State DRAIN:
  - flag_rdy_o=0, bpc_rdy_o=1; accepted words are discarded.
  - When block_cnt wraps to 0, go to RUN.
  - Output register keeps draining independently.
- Final BPC word of a stream is either:
  - the word consumed when block_cnt becomes 0 in DRAIN; or
  - the word consumed in RUN together with flag_last_i=1, when that takes block_cnt to 0.
- Last checking:
  - bpc_last_i=1 on any other consumed word -> err_o=1 next cycle.
  - bpc_last_i=0 on the final word -> err_o=1 next cycle.
  - Processing continues unchanged after either error.
- Streams with no nonzero words consume no BPC words and take no DRAIN.
- idle_o = (state==RUN) && block_cnt==0 && !vld_o.
- Simultaneous output pop and new load in one cycle is supported (full throughput, 1 word/cycle).

Decomposition:
- ebpc_pkg already holds DATA_W and BLOCK_SIZE; add the state enum (RUN, DRAIN) there as dec_merge_state_t.
- No sub-module; the output stage is inline.
- ebpc_decoder instantiates zrle_decoder, bpc_decoder and this block.

Test Plan:
- Zero re-insertion with padding: flags 0,1,0,1(last); BPC 0x11,0x22, then six 0x00 with last on the 8th word -> data 0x00,0x11,0x00,0x22, last on 4th; 6 pads discarded; err_o never 1; idle_o=1 after.
- Full block, no drain: 8 flags=1, last on 8th; BPC 0x01..0x08, last on 8th -> output 0x01..0x08, last on 8th; state stays RUN.
- All-zero stream: 5 flags=0, last on 5th; bpc_vld_i=1 throughout -> five 0x00, last on 5th; bpc_rdy_o never 1.
- Backpressure: scenario 1 with rdy_i random 50% and bpc_vld_i gaps -> identical output sequence; data_o/last_o stable while stalled; no loss or duplication.
- Last errors:
  - bpc_last_i=1 on the 2nd BPC word of scenario 1 -> one err_o pulse; output data unchanged.
  - Omitting last on the 8th word -> one err_o pulse.
- Reset mid-DRAIN: assert rst_i after 2 pads -> vld_o=0, idle_o=1 next cycle; scenario 2 then decodes correctly.
